// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and writeback unit.
// Captures MEM-stage results, formats the writeback value (including load
// sign/zero extension), drives the register file write port, exposes a
// forwarding tap for EX-stage bypass and counts retired instructions.
//
// Stage control semantics: an instruction enters when neither stall nor
// flush is asserted; mem_valid qualifies it. flush kills the held
// instruction even if stall is also asserted. stall holds all captured
// state but drops write_pending, so reg_write is a one-cycle pulse per
// instruction.
module mem_wb_writeback #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_rd,
    input  logic [1:0]       mem_wb_sel,
    input  logic [2:0]       mem_funct3,
    input  logic [XLEN-1:0]  mem_alu_result,
    input  logic [XLEN-1:0]  mem_read_data,
    input  logic [XLEN-1:0]  mem_pc_plus4,
    input  logic             stall,
    input  logic             flush,
    output logic [4:0]       rd,
    output logic [XLEN-1:0]  writedata,
    output logic             reg_write,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic [CNT_W-1:0] retire_count
);

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    logic             valid_q;
    logic             write_pending_q;
    logic             reg_write_q;
    logic [4:0]       rd_q;
    logic [1:0]       wb_sel_q;
    logic [2:0]       funct3_q;
    logic [XLEN-1:0]  alu_q;
    logic [XLEN-1:0]  rdata_q;
    logic [XLEN-1:0]  pc4_q;
    logic [CNT_W-1:0] retire_q;

    logic [7:0]       load_byte;
    logic [15:0]      load_half;
    logic [31:0]      load_word;
    logic [XLEN-1:0]  load_value;
    logic [XLEN-1:0]  wb_value;

    // Stage register: flush beats stall beats capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q         <= 1'b0;
            write_pending_q <= 1'b0;
            reg_write_q     <= 1'b0;
            rd_q            <= '0;
            wb_sel_q        <= '0;
            funct3_q        <= '0;
            alu_q           <= '0;
            rdata_q         <= '0;
            pc4_q           <= '0;
            retire_q        <= '0;
        end else if (flush) begin
            valid_q         <= 1'b0;
            write_pending_q <= 1'b0;
        end else if (stall) begin
            write_pending_q <= 1'b0;
        end else begin
            valid_q         <= mem_valid;
            write_pending_q <= mem_valid & mem_reg_write & (mem_rd != 5'd0);
            reg_write_q     <= mem_reg_write;
            rd_q            <= mem_rd;
            wb_sel_q        <= mem_wb_sel;
            funct3_q        <= mem_funct3;
            alu_q           <= mem_alu_result;
            rdata_q         <= mem_read_data;
            pc4_q           <= mem_pc_plus4;
            if (mem_valid) begin
                retire_q <= retire_q + 1'b1;
            end
        end
    end

    // Load lane extraction and extension from the registered doubleword.
    always_comb begin
        load_byte  = rdata_q[{alu_q[2:0], 3'b000} +: 8];
        load_half  = rdata_q[{alu_q[2:1], 4'b0000} +: 16];
        load_word  = rdata_q[{alu_q[2], 5'b00000} +: 32];
        load_value = rdata_q;
        case (funct3_q)
            3'b000:  load_value = {{(XLEN-8){load_byte[7]}}, load_byte};
            3'b001:  load_value = {{(XLEN-16){load_half[15]}}, load_half};
            3'b010:  load_value = {{(XLEN-32){load_word[31]}}, load_word};
            3'b100:  load_value = {{(XLEN-8){1'b0}}, load_byte};
            3'b101:  load_value = {{(XLEN-16){1'b0}}, load_half};
            3'b110:  load_value = {{(XLEN-32){1'b0}}, load_word};
            default: load_value = rdata_q;
        endcase
    end

    // Writeback source select; the reserved encoding behaves as ALU.
    always_comb begin
        wb_value = alu_q;
        case (wb_sel_q)
            WB_ALU:  wb_value = alu_q;
            WB_LOAD: wb_value = load_value;
            WB_PC4:  wb_value = pc4_q;
            default: wb_value = alu_q;
        endcase
    end

    // Register file port and forwarding tap; x0 is never written or forwarded.
    always_comb begin
        rd           = rd_q;
        writedata    = wb_value;
        reg_write    = write_pending_q;
        fwd_valid    = valid_q & reg_write_q & (rd_q != 5'd0);
        fwd_rd       = rd_q;
        fwd_data     = wb_value;
        retire_count = retire_q;
    end

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed testbench for mem_wb_writeback.
module tb_mem_wb_writeback;

  localparam int XLEN  = 64;
  localparam int CNT_W = 64;

  logic             clk;
  logic             reset;
  logic             mem_valid;
  logic             mem_reg_write;
  logic [4:0]       mem_rd;
  logic [1:0]       mem_wb_sel;
  logic [2:0]       mem_funct3;
  logic [XLEN-1:0]  mem_alu_result;
  logic [XLEN-1:0]  mem_read_data;
  logic [XLEN-1:0]  mem_pc_plus4;
  logic             stall;
  logic             flush;
  logic [4:0]       rd;
  logic [XLEN-1:0]  writedata;
  logic             reg_write;
  logic             fwd_valid;
  logic [4:0]       fwd_rd;
  logic [XLEN-1:0]  fwd_data;
  logic [CNT_W-1:0] retire_count;

  int total = 0;
  int bad   = 0;
  logic [CNT_W-1:0] exp_retire;
  logic [XLEN-1:0]  exp_q[$];

  mem_wb_writeback #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
    .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
    .mem_pc_plus4(mem_pc_plus4), .stall(stall), .flush(flush),
    .rd(rd), .writedata(writedata), .reg_write(reg_write),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retire_count(retire_count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] r,
                       input logic [1:0] sel, input logic [2:0] f3,
                       input logic [XLEN-1:0] alu, input logic [XLEN-1:0] rdata,
                       input logic [XLEN-1:0] pc4);
    mem_valid      = v;
    mem_reg_write  = rw;
    mem_rd         = r;
    mem_wb_sel     = sel;
    mem_funct3     = f3;
    mem_alu_result = alu;
    mem_read_data  = rdata;
    mem_pc_plus4   = pc4;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, '0, '0, '0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    idle();
    exp_retire = '0;
    #12;
    total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL reset_reg_write got=%b exp=0", reg_write); end
    total++; if (fwd_valid !== 1'b0) begin bad++; $display("FAIL reset_fwd_valid got=%b exp=0", fwd_valid); end
    total++; if (rd !== 5'd0 || fwd_rd !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0d/%0d exp=0", rd, fwd_rd); end
    total++; if (writedata !== '0 || fwd_data !== '0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0", writedata, fwd_data); end
    total++; if (retire_count !== '0) begin bad++; $display("FAIL reset_retire got=%0d exp=0", retire_count); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    drive(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 64'h1234, 64'hFFFF, 64'h44);
    exp_retire = exp_retire + 1;
    tick();
    idle();
    total++; if (reg_write !== 1'b1) begin bad++; $display("FAIL alu_reg_write got=%b exp=1", reg_write); end
    total++; if (rd !== 5'd5) begin bad++; $display("FAIL alu_rd got=%0d exp=5", rd); end
    total++; if (writedata !== 64'h1234) begin bad++; $display("FAIL alu_data got=%h exp=%h", writedata, 64'h1234); end
    total++; if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 64'h1234) begin bad++; $display("FAIL alu_fwd got=%b/%0d/%h exp=1/5/1234", fwd_valid, fwd_rd, fwd_data); end
    total++; if (retire_count !== exp_retire) begin bad++; $display("FAIL alu_retire got=%0d exp=%0d", retire_count, exp_retire); end
    tick();
    total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL alu_pulse got=%b exp=0", reg_write); end
    total++; if (fwd_valid !== 1'b0) begin bad++; $display("FAIL alu_fwd_drop got=%b exp=0", fwd_valid); end
    total++; if (retire_count !== exp_retire) begin bad++; $display("FAIL alu_retire_idle got=%0d exp=%0d", retire_count, exp_retire); end
  endtask

  task automatic test_loads();
    logic [2:0]      f3_t  [10];
    logic [XLEN-1:0] adr_t [10];
    logic [XLEN-1:0] dat_t [10];
    logic [XLEN-1:0] exp_t [10];
    logic [XLEN-1:0] exp_v;
    f3_t[0] = 3'b000; adr_t[0] = 64'h1003; dat_t[0] = 64'h00000000_80000000; exp_t[0] = 64'hFFFFFFFF_FFFFFF80;
    f3_t[1] = 3'b100; adr_t[1] = 64'h1003; dat_t[1] = 64'h00000000_80000000; exp_t[1] = 64'h00000000_00000080;
    f3_t[2] = 3'b110; adr_t[2] = 64'h2004; dat_t[2] = 64'hDEADBEEF_00000000; exp_t[2] = 64'h00000000_DEADBEEF;
    f3_t[3] = 3'b010; adr_t[3] = 64'h2007; dat_t[3] = 64'hDEADBEEF_00000000; exp_t[3] = 64'hFFFFFFFF_DEADBEEF;
    f3_t[4] = 3'b001; adr_t[4] = 64'h3003; dat_t[4] = 64'h00000000_9ABC0000; exp_t[4] = 64'hFFFFFFFF_FFFF9ABC;
    f3_t[5] = 3'b101; adr_t[5] = 64'h3002; dat_t[5] = 64'h00000000_9ABC0000; exp_t[5] = 64'h00000000_00009ABC;
    f3_t[6] = 3'b011; adr_t[6] = 64'h4007; dat_t[6] = 64'h01234567_89ABCDEF; exp_t[6] = 64'h01234567_89ABCDEF;
    f3_t[7] = 3'b111; adr_t[7] = 64'h4005; dat_t[7] = 64'hFEDCBA98_76543210; exp_t[7] = 64'hFEDCBA98_76543210;
    f3_t[8] = 3'b000; adr_t[8] = 64'h5007; dat_t[8] = 64'h7F000000_000000FF; exp_t[8] = 64'h00000000_0000007F;
    f3_t[9] = 3'b010; adr_t[9] = 64'h5000; dat_t[9] = 64'h00000000_7FFFFFFF; exp_t[9] = 64'h00000000_7FFFFFFF;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 5'(10 + i), 2'b01, f3_t[i], adr_t[i], dat_t[i], 64'h0);
      exp_q.push_back(exp_t[i]);
      exp_retire = exp_retire + 1;
      tick();
      exp_v = exp_q.pop_front();
      total++; if (writedata !== exp_v || reg_write !== 1'b1 || rd !== 5'(10 + i)) begin bad++; $display("FAIL load_%0d got=%h we=%b rd=%0d exp=%h we=1 rd=%0d", i, writedata, reg_write, rd, exp_v, 10 + i); end
    end
    idle();
    total++; if (retire_count !== exp_retire) begin bad++; $display("FAIL load_retire got=%0d exp=%0d", retire_count, exp_retire); end
  endtask

  task automatic test_sel();
    drive(1'b1, 1'b1, 5'd3, 2'b10, 3'b000, 64'h55, 64'h66, 64'h0000_1000);
    exp_retire = exp_retire + 1;
    tick();
    total++; if (writedata !== 64'h1000) begin bad++; $display("FAIL sel_pc4 got=%h exp=%h", writedata, 64'h1000); end
    drive(1'b1, 1'b1, 5'd4, 2'b11, 3'b000, 64'h55, 64'h66, 64'h0000_1000);
    exp_retire = exp_retire + 1;
    tick();
    idle();
    total++; if (writedata !== 64'h55 || reg_write !== 1'b1) begin bad++; $display("FAIL sel_reserved got=%h we=%b exp=55 we=1", writedata, reg_write); end
  endtask

  task automatic test_x0();
    drive(1'b1, 1'b1, 5'd0, 2'b10, 3'b000, 64'h1, 64'h2, 64'h3);
    exp_retire = exp_retire + 1;
    tick();
    idle();
    total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL x0_reg_write got=%b exp=0", reg_write); end
    total++; if (fwd_valid !== 1'b0) begin bad++; $display("FAIL x0_fwd_valid got=%b exp=0", fwd_valid); end
    total++; if (retire_count !== exp_retire) begin bad++; $display("FAIL x0_retire got=%0d exp=%0d", retire_count, exp_retire); end
    // a valid instruction without reg_write also retires but neither writes nor forwards
    drive(1'b1, 1'b0, 5'd9, 2'b00, 3'b000, 64'h9, 64'h0, 64'h0);
    exp_retire = exp_retire + 1;
    tick();
    idle();
    total++; if (reg_write !== 1'b0 || fwd_valid !== 1'b0 || retire_count !== exp_retire) begin bad++; $display("FAIL nowrite got=%b/%b/%0d exp=0/0/%0d", reg_write, fwd_valid, retire_count, exp_retire); end
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b1, 5'd7, 2'b00, 3'b000, 64'hAAAA_0000_BBBB, 64'h0, 64'h0);
    exp_retire = exp_retire + 1;
    tick();
    total++; if (reg_write !== 1'b1 || rd !== 5'd7) begin bad++; $display("FAIL stall_first got=%b rd=%0d exp=1 rd=7", reg_write, rd); end
    drive(1'b1, 1'b1, 5'd9, 2'b00, 3'b000, 64'hCCCC, 64'h0, 64'h0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL stall_we_%0d got=%b exp=0", i, reg_write); end
      total++; if (fwd_valid !== 1'b1 || fwd_rd !== 5'd7 || fwd_data !== 64'hAAAA_0000_BBBB) begin bad++; $display("FAIL stall_fwd_%0d got=%b/%0d/%h exp=1/7/aaaa0000bbbb", i, fwd_valid, fwd_rd, fwd_data); end
      total++; if (retire_count !== exp_retire) begin bad++; $display("FAIL stall_retire_%0d got=%0d exp=%0d", i, retire_count, exp_retire); end
    end
    stall = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b1, 5'd8, 2'b00, 3'b000, 64'h88, 64'h0, 64'h0);
    exp_retire = exp_retire + 1;
    tick();
    total++; if (fwd_valid !== 1'b1) begin bad++; $display("FAIL flush_pre got=%b exp=1", fwd_valid); end
    drive(1'b1, 1'b1, 5'd12, 2'b00, 3'b000, 64'h99, 64'h0, 64'h0);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    stall = 1'b0;
    flush = 1'b0;
    idle();
    total++; if (fwd_valid !== 1'b0 || reg_write !== 1'b0) begin bad++; $display("FAIL flush_kill got=%b/%b exp=0/0", fwd_valid, reg_write); end
    total++; if (retire_count !== exp_retire) begin bad++; $display("FAIL flush_retire got=%0d exp=%0d", retire_count, exp_retire); end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] exp_v;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 5'(20 + i), 2'b00, 3'b000, 64'(32'h1000 * (i + 1)), 64'h0, 64'h0);
      exp_q.push_back(64'(32'h1000 * (i + 1)));
      exp_retire = exp_retire + 1;
      tick();
      exp_v = exp_q.pop_front();
      total++; if (writedata !== exp_v || reg_write !== 1'b1 || fwd_rd !== 5'(20 + i)) begin bad++; $display("FAIL b2b_%0d got=%h we=%b rd=%0d exp=%h we=1 rd=%0d", i, writedata, reg_write, fwd_rd, exp_v, 20 + i); end
    end
    idle();
    total++; if (retire_count !== exp_retire) begin bad++; $display("FAIL b2b_retire got=%0d exp=%0d", retire_count, exp_retire); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 5'd6, 2'b00, 3'b000, 64'h66, 64'h0, 64'h0);
    tick();
    idle();
    total++; if (reg_write !== 1'b1) begin bad++; $display("FAIL areset_pre got=%b exp=1", reg_write); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (reg_write !== 1'b0 || fwd_valid !== 1'b0) begin bad++; $display("FAIL areset_enables got=%b/%b exp=0/0", reg_write, fwd_valid); end
    total++; if (retire_count !== '0) begin bad++; $display("FAIL areset_retire got=%0d exp=0", retire_count); end
    @(negedge clk);
    total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL areset_negedge got=%b exp=0", reg_write); end
    #2;
    reset = 1'b1;
    exp_retire = '0;
    tick();
    total++; if (reg_write !== 1'b0 || retire_count !== exp_retire) begin bad++; $display("FAIL areset_after got=%b/%0d exp=0/0", reg_write, retire_count); end
  endtask

  // test sequence and final report
  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_sel();
    test_x0();
    test_stall();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
